// File: rtl/coherency_config_responder.sv
// ---------------------------------------------------------------------------
// coherency_config_responder
//
// Responder end of the coherency configure handshake, living in the coherent
// manager. The memory controller hands over one {base address, line count}
// configuration per cfg_valid/cfg_ack transfer. The block then walks that
// region one cache line at a time and offers each line-aligned address to
// the watch table over a valid/ready stream. While a walk is in progress
// cfg_ack is held low, so a second configuration cannot arrive mid-walk.
//
// Parameters
//   ADDR_W      width of base and watch addresses
//   SIZE_W      width of the cache-line count
//   LINE_BYTES  cache line size in bytes (power of two, at least 2)
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active-high
//   cfg_valid      configuration offered by the memory controller
//   cfg_base_addr  first byte address of the region (any alignment)
//   cfg_size       number of cache lines in the region (0 is legal)
//   cfg_ack        registered ready/ack; a transfer is cfg_valid && cfg_ack
//   watch_valid    a watch address is being offered
//   watch_ready    the watch table can take the offered address
//   watch_addr     line-aligned address being offered (0 when idle)
//   watch_last     the offered address is the final line of the region
//   cfg_done       one-cycle pulse once a configuration is fully issued
//   busy           high while the region is being walked
// ---------------------------------------------------------------------------
module coherency_config_responder #(
    parameter int ADDR_W     = 64,
    parameter int SIZE_W     = 32,
    parameter int LINE_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [SIZE_W-1:0] cfg_size,
    output logic              cfg_ack,
    output logic              watch_valid,
    input  logic              watch_ready,
    output logic [ADDR_W-1:0] watch_addr,
    output logic              watch_last,
    output logic              cfg_done,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    // LINE_BYTES is a power of two, so clearing the offset bits is a mask
    // with the low log2(LINE_BYTES) bits zero.
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(LINE_STEP - ADDR_W'(1));

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   cur_addr_q;
    logic [ADDR_W-1:0]   cur_addr_d;
    logic [SIZE_W-1:0]   remaining_q;
    logic [SIZE_W-1:0]   remaining_d;
    logic                ack_q;
    logic                ack_d;
    logic                done_q;
    logic                done_d;

    logic                walking;
    logic                last_line;
    logic                accept;
    logic                handshake;

    // Decoded views of the current state shared by the next-state logic and
    // the outputs. accept uses the registered ack, so the acceptance path
    // never feeds back combinationally into cfg_ack.
    assign walking   = (state_q == WALK);
    assign last_line = (remaining_q == SIZE_W'(1));
    assign accept    = cfg_valid && ack_q;
    assign handshake = walking && watch_ready;

    // State register. Everything, including the ack and done flops, clears
    // asynchronously so a reset in the middle of a walk abandons it at once
    // and never leaves a stray cfg_done pulse behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic.
    // IDLE raises ack on the first edge after reset and keeps it up. A
    // zero-length configuration is swallowed in place and only produces the
    // done pulse; a non-empty one latches the aligned base and the line count
    // and drops ack for the duration of the walk.
    // WALK advances one line per accepted address. The address adder simply
    // wraps at the top of the address space. When the final line is taken the
    // block returns to IDLE with ack raised and done pulsed in the same cycle,
    // which gives the N+1 cycle minimum spacing between configurations.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        ack_d       = ack_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                ack_d = 1'b1;
                if (accept) begin
                    if (cfg_size == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = WALK;
                        ack_d       = 1'b0;
                        cur_addr_d  = cfg_base_addr & LINE_MASK;
                        remaining_d = cfg_size;
                    end
                end
            end

            WALK: begin
                ack_d = 1'b0;
                if (handshake) begin
                    cur_addr_d  = cur_addr_q + LINE_STEP;
                    remaining_d = remaining_q - SIZE_W'(1);
                    if (last_line) begin
                        state_d = IDLE;
                        ack_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Outputs are decoded purely from registered state, so they hold steady
    // for as long as the watch table stalls. The address is forced to zero
    // outside a walk so idle cycles do not expose a stale line.
    assign cfg_ack     = ack_q;
    assign cfg_done    = done_q;
    assign busy        = walking;
    assign watch_valid = walking;
    assign watch_last  = walking && last_line;
    assign watch_addr  = walking ? cur_addr_q : '0;

endmodule

// File: tb/tb_coherency_config_responder.sv
// ---------------------------------------------------------------------------
// tb_coherency_config_responder
//
// Self-checking bench for coherency_config_responder. A reference model keeps
// the active region as {aligned base, total lines, lines issued} and derives
// every expected output from that with plain arithmetic. A table of
// configurations with hand-computed first/last addresses and handshake
// counts is run first, then hand-written corner sequences (zero size,
// back-to-back, reset mid-walk, maximum size), then randomized traffic.
// ---------------------------------------------------------------------------
module tb_coherency_config_responder;

    localparam int ADDR_W     = 64;
    localparam int SIZE_W     = 32;
    localparam int LINE_BYTES = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [ADDR_W-1:0] cfg_base_addr = '0;
    logic [SIZE_W-1:0] cfg_size = '0;
    logic              cfg_ack;
    logic              watch_valid;
    logic              watch_ready = 1'b0;
    logic [ADDR_W-1:0] watch_addr;
    logic              watch_last;
    logic              cfg_done;
    logic              busy;

    coherency_config_responder #(
        .ADDR_W     (ADDR_W),
        .SIZE_W     (SIZE_W),
        .LINE_BYTES (LINE_BYTES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_base_addr (cfg_base_addr),
        .cfg_size      (cfg_size),
        .cfg_ack       (cfg_ack),
        .watch_valid   (watch_valid),
        .watch_ready   (watch_ready),
        .watch_addr    (watch_addr),
        .watch_last    (watch_last),
        .cfg_done      (cfg_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: out of reset flag, region description, done pulse.
    logic              m_out;
    logic              m_walk;
    logic              m_done;
    logic [ADDR_W-1:0] m_base;
    longint unsigned   m_idx;
    longint unsigned   m_total;

    // Handshake bookkeeping for the current configuration.
    int                hs_count;
    int                last_flag_count;
    logic [ADDR_W-1:0] hs_first;
    logic [ADDR_W-1:0] hs_last;
    logic [ADDR_W-1:0] last_flag_addr;
    logic              done_seen;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [SIZE_W-1:0] size;
        logic [7:0]        ready_pat;
        logic [ADDR_W-1:0] exp_first;
        logic [ADDR_W-1:0] exp_last;
        int                exp_hs;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_out   = 1'b0;
        m_walk  = 1'b0;
        m_done  = 1'b0;
        m_base  = '0;
        m_idx   = 0;
        m_total = 0;
    endtask

    // One clock edge of the model, using the inputs the bench is holding.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (m_walk) begin
                if (watch_ready) begin
                    m_idx++;
                    if (m_idx == m_total) begin
                        m_walk = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (m_out && cfg_valid) begin
                if (cfg_size == '0) begin
                    m_done = 1'b1;
                end else begin
                    m_walk  = 1'b1;
                    m_base  = cfg_base_addr - (cfg_base_addr % 64'(LINE_BYTES));
                    m_total = longint'(cfg_size);
                    m_idx   = 0;
                end
            end
            m_out = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [ADDR_W-1:0] exp_addr;
        exp_addr = m_walk ? (m_base + 64'(m_idx) * 64'(LINE_BYTES)) : '0;
        check({tag, " cfg_ack"},     cfg_ack,     m_out && !m_walk);
        check({tag, " watch_valid"}, watch_valid, m_walk);
        check({tag, " watch_addr"},  watch_addr,  exp_addr);
        check({tag, " watch_last"},  watch_last,  m_walk && (m_idx + 1 == m_total));
        check({tag, " cfg_done"},    cfg_done,    m_done);
        check({tag, " busy"},        busy,        m_walk);
        if (cfg_done) done_seen = 1'b1;
    endtask

    // Drive inputs one step after an edge, note any handshake that will
    // happen on the coming edge, clock, update the model, then check.
    task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] b,
                                 input logic [SIZE_W-1:0] s, input logic r,
                                 input string tag);
        cfg_valid     = v;
        cfg_base_addr = b;
        cfg_size      = s;
        watch_ready   = r;
        #1;
        if (watch_valid && watch_ready) begin
            if (hs_count == 0) hs_first = watch_addr;
            hs_last = watch_addr;
            hs_count++;
            if (watch_last) begin
                last_flag_count++;
                last_flag_addr = watch_addr;
            end
        end
        @(posedge clk);
        model_step();
        #1;
        checkOutput(tag);
    endtask

    task automatic clear_tracking();
        hs_count        = 0;
        last_flag_count = 0;
        hs_first        = '0;
        hs_last         = '0;
        last_flag_addr  = '0;
        done_seen       = 1'b0;
    endtask

    // Offer one configuration and follow it to cfg_done, with watch_ready
    // taken from the pattern for the first eight walk cycles.
    task automatic run_config(input logic [ADDR_W-1:0] b, input logic [SIZE_W-1:0] s,
                              input logic [7:0] pat, input string tag);
        clear_tracking();
        applyStimulus(1'b1, b, s, 1'b1, tag);
        for (int k = 0; k < 100 && !done_seen; k++) begin
            applyStimulus(1'b0, '0, '0, (k < 8) ? pat[k] : 1'b1, tag);
        end
        check({tag, " done within budget"}, done_seen, 1'b1);
    endtask

    initial begin
        vecs[0] = '{64'h1000, 32'd3, 8'hFF, 64'h1000, 64'h1080, 3};
        vecs[1] = '{64'h2013, 32'd2, 8'b1111_1001, 64'h2000, 64'h2040, 2};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFC0, 32'd2, 8'hFF, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0, 2};
        vecs[3] = '{64'h7FFF, 32'd1, 8'b0101_0010, 64'h7FC0, 64'h7FC0, 1};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 32'd4, 8'b1011_0110, 64'h1234_5678_9ABC_DEC0,
                    64'h1234_5678_9ABC_DF80, 4};
        vecs[5] = '{64'h5000, 32'd0, 8'hFF, 64'h0, 64'h0, 0};

        model_reset();
        clear_tracking();

        // Reset held: ack low, no watch traffic.
        #1;
        applyStimulus(1'b0, '0, '0, 1'b0, "in reset");
        applyStimulus(1'b1, 64'h1000, 32'd3, 1'b1, "in reset valid");
        rst = 1'b0;
        #1;
        check("ack right after release", cfg_ack, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, "first edge after release");
        check("ack one edge after release", cfg_ack, 1'b1);

        // Table of configurations.
        foreach (vecs[i]) begin
            run_config(vecs[i].base, vecs[i].size, vecs[i].ready_pat, $sformatf("vec%0d", i));
            check($sformatf("vec%0d handshakes", i), 64'(hs_count), 64'(vecs[i].exp_hs));
            check($sformatf("vec%0d first addr", i), hs_first, vecs[i].exp_first);
            check($sformatf("vec%0d last addr", i), hs_last, vecs[i].exp_last);
            check($sformatf("vec%0d last flags", i), 64'(last_flag_count),
                  (vecs[i].exp_hs > 0) ? 64'd1 : 64'd0);
            check($sformatf("vec%0d last flag addr", i), last_flag_addr, vecs[i].exp_last);
        end

        // Zero size followed immediately by a one-line configuration.
        clear_tracking();
        applyStimulus(1'b1, 64'h5000, 32'd0, 1'b1, "size0");
        check("size0 done pulse", cfg_done, 1'b1);
        check("size0 ack held", cfg_ack, 1'b1);
        check("size0 no watch", watch_valid, 1'b0);
        applyStimulus(1'b1, 64'h6000, 32'd1, 1'b1, "b2b accept");
        check("b2b busy", busy, 1'b1);
        check("b2b addr", watch_addr, 64'h6000);
        check("b2b last", watch_last, 1'b1);
        check("b2b done single cycle", cfg_done, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, "b2b finish");
        check("b2b done", cfg_done, 1'b1);
        check("b2b ack back", cfg_ack, 1'b1);

        // Reset after the third line of an eight-line walk, with another
        // configuration held on the bus the whole time.
        clear_tracking();
        applyStimulus(1'b1, 64'h8000, 32'd8, 1'b1, "midrst accept");
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 64'h9000, 32'd5, 1'b1, "midrst walk");
        check("midrst handshakes before reset", 64'(hs_count), 64'd3);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst async ack",   cfg_ack,     1'b0);
        check("midrst async valid", watch_valid, 1'b0);
        check("midrst async addr",  watch_addr,  64'h0);
        check("midrst async last",  watch_last,  1'b0);
        check("midrst async done",  cfg_done,    1'b0);
        check("midrst async busy",  busy,        1'b0);
        applyStimulus(1'b1, 64'h9000, 32'd5, 1'b1, "midrst held");
        applyStimulus(1'b1, 64'h9000, 32'd5, 1'b1, "midrst held");
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, "midrst release");
        check("midrst no done", done_seen, 1'b0);
        run_config(64'h3000, 32'd1, 8'hFF, "after midrst");
        check("after midrst handshakes", 64'(hs_count), 64'd1);
        check("after midrst addr", hs_first, 64'h3000);

        // Maximum size: check the start of the walk, then abandon it.
        clear_tracking();
        applyStimulus(1'b1, 64'h40, 32'hFFFF_FFFF, 1'b1, "maxsize");
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, '0, '0, 1'b1, "maxsize walk");
        check("maxsize handshakes", 64'(hs_count), 64'd20);
        check("maxsize addr", watch_addr, 64'h40 + 64'd20 * 64'd64);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        applyStimulus(1'b0, '0, '0, 1'b0, "maxsize reset");
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, "maxsize release");

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom},
                          SIZE_W'($urandom_range(0, 5)), ($urandom_range(0, 9) < 7),
                          "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coherency_config_responder.md
Name: coherency_config_responder

Overview:
Slave (responder) end of the coherency configure handshake, placed in the coherent manager.
- Accepts one {base_addr, size} configuration per valid/ack transfer from the memory controller.
- Expands the configuration into a stream of cache-line-aligned watch addresses, one per handshake, toward the coherent manager's watch table.
- Deasserts ack while expanding, so a new configuration cannot be taken mid-walk.

Parameters:
ADDR_W, 64, width of addr_t (base and watch addresses)
SIZE_W, 32, width of size_t (cache-line count)
LINE_BYTES, 64, cache line size in bytes; power of two ≥ 2

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
cfg_valid  input  1  configuration valid from master
cfg_base_addr  input  ADDR_W  base address to watch
cfg_size  input  SIZE_W  number of cache lines to watch
cfg_ack  output  1  ready/ack; transfer when cfg_valid && cfg_ack
watch_valid  output  1  watch address valid
watch_ready  input  1  downstream watch table ready
watch_addr  output  ADDR_W  line-aligned address to watch
watch_last  output  1  current watch_addr is the final line of the configuration
cfg_done  output  1  one-cycle pulse when a configuration is fully issued
busy  output  1  high in WALK

Behaviour:
- Single clock. All state is reset asynchronously by rst.
- Reset values:
  - cfg_ack=0, watch_valid=0, watch_addr=0, watch_last=0, cfg_done=0, busy=0
  - state=IDLE, cur_addr=0, remaining=0
- States: IDLE, WALK.
- IDLE:
  - cfg_ack=1 from the first clock edge after rst deasserts (registered).
  - On cfg_valid && cfg_ack with cfg_size==0: stay in IDLE, cfg_ack stays 1, cfg_done pulses next cycle, no watch traffic.
  - On cfg_valid && cfg_ack with cfg_size>0: next cycle state=WALK, cfg_ack=0, busy=1.
    - Latch cur_addr = cfg_base_addr with the low log2(LINE_BYTES) bits cleared.
    - Latch remaining = cfg_size.
- WALK:
  - watch_valid=1, watch_addr=cur_addr, watch_last=(remaining==1).
  - Outputs are stable while watch_ready=0.
  - On watch_valid && watch_ready:
    - cur_addr += LINE_BYTES, modulo 2^ADDR_W (wraps silently past the top of the address space).
    - remaining -= 1.
    - If watch_last: next cycle state=IDLE, watch_valid=0, busy=0, cfg_ack=1, cfg_done=1 for one cycle.
- Throughput: one line per cycle when watch_ready is held high. A size-N configuration occupies N cycles of WALK.
- Minimum gap between accepted configurations: N+1 cycles.
- cfg_valid while cfg_ack=0 is ignored; the master must hold it per the ready/valid rules.
- watch_valid must not drop before the handshake. watch_addr/watch_last are stable while watch_valid && !watch_ready.
- cfg_size is an unsigned count. The maximum (2^SIZE_W−1) is legal and walks to completion.
- rst asserted mid-walk: the walk is aborted immediately and all outputs return to reset values. No partial cfg_done.
- cfg_ack never depends combinationally on cfg_valid.

Test Plan:
1. Reset, then release: cfg_ack=0 during rst, cfg_ack=1 one cycle after release; watch_valid=0 throughout.
2. Base 0x1000, size 3, watch_ready=1:
   - watch_addr 0x1000, 0x1040, 0x1080 on consecutive cycles; watch_last only on 0x1080.
   - cfg_done pulse and cfg_ack=1 the following cycle; cfg_ack=0 during the walk.
3. Base 0x2013 (unaligned), size 2, watch_ready toggled 1-0-0-1:
   - Addresses 0x2000 then 0x2040.
   - 0x2040 is held stable across the stall cycles; exactly 2 handshakes occur.
4. Size 0 at base 0x5000: no watch_valid, cfg_done pulses one cycle later, cfg_ack stays 1. A back-to-back size-1 config on the next cycle is accepted.
5. Base 0xFFFF_FFFF_FFFF_FFC0, size 2: addresses 0xFFFF_FFFF_FFFF_FFC0 then 0x0 (wrap); watch_last on 0x0.
6. Size 8, assert rst after the 3rd handshake:
   - All outputs go to reset values asynchronously; no cfg_done.
   - After release, a new config base 0x3000, size 1 produces the single address 0x3000. cfg_valid driven during the prior walk caused no acceptance.
